// File: rtl/sseg_scan.sv
// Four-digit multiplexed seven-segment driver with a per-frame snapshot of the
// display word, optional leading-zero blanking, per-digit enable and decimal point.
module sseg_scan #(
   parameter int unsigned N   = 18,
   parameter bit          LZB = 1'b0
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [15:0] value,
   input  logic [3:0]  dig_en,
   input  logic [3:0]  dp,
   output logic [3:0]  an,
   output logic [7:0]  sseg,
   output logic        frame_tick
);

   logic [N-1:0] cnt;
   logic [15:0]  val_q;
   logic [3:0]   en_q;
   logic [3:0]   dp_q;
   logic [1:0]   sel;
   logic         wrap;
   logic [3:0]   nib;
   logic [3:0]   upper_zero;
   logic         blank;
   logic [3:0]   an_d;
   logic [7:0]   sseg_d;

   function automatic logic [6:0] hex(input logic [3:0] h);
      case (h)
         4'h0: hex = 7'h40;
         4'h1: hex = 7'h79;
         4'h2: hex = 7'h24;
         4'h3: hex = 7'h30;
         4'h4: hex = 7'h19;
         4'h5: hex = 7'h12;
         4'h6: hex = 7'h02;
         4'h7: hex = 7'h78;
         4'h8: hex = 7'h00;
         4'h9: hex = 7'h10;
         4'hA: hex = 7'h08;
         4'hB: hex = 7'h03;
         4'hC: hex = 7'h46;
         4'hD: hex = 7'h21;
         4'hE: hex = 7'h06;
         default: hex = 7'h0E;
      endcase
   endfunction

   assign sel  = cnt[N-1 -: 2];
   assign wrap = &cnt;

   always_comb begin
      nib        = 4'h0;
      upper_zero = '0;
      blank      = 1'b0;
      an_d       = '1;
      sseg_d     = '1;

      case (sel)
         2'd0:    nib = val_q[3:0];
         2'd1:    nib = val_q[7:4];
         2'd2:    nib = val_q[11:8];
         default: nib = val_q[15:12];
      endcase

      // upper_zero[d]: nibbles d..3 of the snapshot are all zero
      upper_zero[3] = (val_q[15:12] == 4'h0);
      upper_zero[2] = upper_zero[3] && (val_q[11:8] == 4'h0);
      upper_zero[1] = upper_zero[2] && (val_q[7:4]  == 4'h0);
      upper_zero[0] = upper_zero[1] && (val_q[3:0]  == 4'h0);

      blank = !en_q[sel] || (LZB && (sel != 2'd0) && upper_zero[sel]);

      if (!blank) begin
         an_d   = ~(4'b0001 << sel);
         sseg_d = {~dp_q[sel], hex(nib)};
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         cnt        <= '1;
         val_q      <= '0;
         en_q       <= '0;
         dp_q       <= '0;
         an         <= '1;
         sseg       <= '1;
         frame_tick <= 1'b0;
      end else begin
         cnt        <= cnt + N'(1);
         frame_tick <= wrap;
         an         <= an_d;
         sseg       <= sseg_d;
         if (wrap) begin
            val_q <= value;
            en_q  <= dig_en;
            dp_q  <= dp;
         end
      end
   end

endmodule

// File: tb/tb_sseg_scan.sv
// Directed self-checking bench for sseg_scan with N=4 (4-cycle slots, 16-cycle frame);
// one instance without and one with leading-zero blanking share all inputs.
module tb_sseg_scan;

   logic        clk;
   logic        clr;
   logic [15:0] value;
   logic [3:0]  dig_en;
   logic [3:0]  dp;
   logic [3:0]  an0, an1;
   logic [7:0]  sseg0, sseg1;
   logic        ft0, ft1;

   int errors = 0;
   int checks = 0;

   sseg_scan #(.N(4), .LZB(1'b0)) dut0 (
      .clk(clk), .clr(clr), .value(value), .dig_en(dig_en), .dp(dp),
      .an(an0), .sseg(sseg0), .frame_tick(ft0)
   );

   sseg_scan #(.N(4), .LZB(1'b1)) dut1 (
      .clk(clk), .clr(clr), .value(value), .dig_en(dig_en), .dp(dp),
      .an(an1), .sseg(sseg1), .frame_tick(ft1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Checks one full frame starting at a digit-0 slot boundary. an_exp/ss_exp hold
   // the expected per-digit outputs (digit 0 in the low field). Inputs switch to
   // the chg_* values just before edge chg_at of the frame.
   task automatic run_frame(input string tag, input bit use_lzb,
                            input logic [15:0] an_exp, input logic [31:0] ss_exp,
                            input int chg_at, input logic [15:0] chg_val,
                            input logic [3:0] chg_en, input logic [3:0] chg_dp);
      for (int i = 0; i < 16; i++) begin
         if (i == chg_at) begin
            value  = chg_val;
            dig_en = chg_en;
            dp     = chg_dp;
         end
         tick();
         chk($sformatf("%s_an_%0d", tag, i), {4'h0, use_lzb ? an1 : an0}, {4'h0, an_exp[(i/4)*4 +: 4]});
         chk($sformatf("%s_sseg_%0d", tag, i), use_lzb ? sseg1 : sseg0, ss_exp[(i/4)*8 +: 8]);
         chk($sformatf("%s_ft_%0d", tag, i), {7'h0, use_lzb ? ft1 : ft0}, {7'h0, (i == 15)});
      end
   endtask

   initial begin
      clr    = 1'b1;
      value  = 16'h12AF;
      dig_en = 4'hF;
      dp     = 4'h0;

      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("rst_an_%0d", i), {4'h0, an0}, 8'h0F);
         chk($sformatf("rst_sseg_%0d", i), sseg0, 8'hFF);
         chk($sformatf("rst_ft_%0d", i), {7'h0, ft0}, 8'h00);
         chk($sformatf("rst_an1_%0d", i), {4'h0, an1}, 8'h0F);
      end
      clr = 1'b0;

      tick();
      chk("e1_ft", {7'h0, ft0}, 8'h01);
      chk("e1_an", {4'h0, an0}, 8'h0F);
      chk("e1_sseg", sseg0, 8'hFF);

      // 12AF frame; 3333 arrives during the digit-1 slot and must not tear it
      run_frame("f12af", 1'b0, 16'h7BDE, 32'hF9A4888E, 5, 16'h3333, 4'hF, 4'h0);
      run_frame("f3333", 1'b0, 16'h7BDE, 32'hB0B0B0B0, 0, 16'h0005, 4'hF, 4'h0);
      run_frame("lz0005", 1'b1, 16'hFFFE, 32'hFFFFFF92, 0, 16'h0000, 4'hF, 4'h0);
      run_frame("lz0000", 1'b1, 16'hFFFE, 32'hFFFFFFC0, 0, 16'h0100, 4'hF, 4'h0);
      run_frame("lz0100", 1'b1, 16'hFBDE, 32'hFFF9C0C0, 0, 16'h0003, 4'b0101, 4'b0001);
      run_frame("en_dp", 1'b0, 16'hFBFE, 32'hFFC0FF30, 0, 16'h0003, 4'b0101, 4'b0001);

      // Reset in the middle of the digit-2 slot
      for (int i = 0; i < 9; i++) tick();
      chk("pre_rst_an", {4'h0, an0}, 8'h0B);
      chk("pre_rst_sseg", sseg0, 8'hC0);
      clr    = 1'b1;
      value  = 16'h12AF;
      dig_en = 4'hF;
      dp     = 4'h0;
      tick();
      chk("mid_rst_an", {4'h0, an0}, 8'h0F);
      chk("mid_rst_sseg", sseg0, 8'hFF);
      chk("mid_rst_ft", {7'h0, ft0}, 8'h00);
      clr = 1'b0;
      tick();
      chk("re_e1_ft", {7'h0, ft0}, 8'h01);
      chk("re_e1_an", {4'h0, an0}, 8'h0F);
      chk("re_e1_sseg", sseg0, 8'hFF);
      run_frame("restart", 1'b0, 16'h7BDE, 32'hF9A4888E, 99, 16'h0000, 4'hF, 4'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
